// File: rtl/hs_pkg.sv
// Shared types for the 4-phase receive bridge and its benches.
package hs_pkg;

    typedef enum bit {IDLE, ACK} t_hs4_rx_state;

    typedef enum bit {FALL, RISE} t_change;

endpackage

// File: rtl/hs_sync.sv
// N-deep synchronizer chain for a single asynchronous bit.
module hs_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/hs4_rx_bridge.sv
// 4-phase bundled-data receiver feeding a 1-entry valid/ready output register.
module hs4_rx_bridge
    import hs_pkg::*;
#(
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_i,
    input  logic [DW-1:0]    data_i,
    output logic             ack_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [DW-1:0]    m_data_o,
    output logic [CNT_W-1:0] xfer_cnt_o
);

    t_hs4_rx_state state;
    t_hs4_rx_state state_nx;
    logic          req_s;
    logic          fire;
    logic          free;
    logic          cap;

    hs_sync #(
        .STAGES(SYNC_STAGES)
    ) u_req_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (req_i),
        .q    (req_s)
    );

    assign fire = m_valid_o & m_ready_i;
    assign free = !m_valid_o | fire;

    always_comb begin
        state_nx = state;
        cap      = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_s && free) begin
                    cap      = 1'b1;
                    state_nx = ACK;
                end
            end
            ACK: begin
                if (!req_s) begin
                    state_nx = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Ack comes straight off the state flop so it never glitches.
    assign ack_o = (state == ACK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_o  <= 1'b0;
            m_data_o   <= '0;
            xfer_cnt_o <= '0;
        end else begin
            if (cap) begin
                m_valid_o <= 1'b1;
                m_data_o  <= data_i;
            end else if (fire) begin
                m_valid_o <= 1'b0;
            end
            if (fire) begin
                xfer_cnt_o <= xfer_cnt_o + 1'b1;
            end
        end
    end

endmodule
